cvt_shift_seq: RTL and testbench

Iterative shift sequencer for the FPU conversion post-processing path. It performs the long normalisation/denormalisation shift of the conversion datapath in STEP-bit chunks over several cycles, instead of one wide single-cycle barrel shift. It accepts a shift-in vector and amount over a valid/ready handshake and returns the shifted value plus sticky/overflow flags over a second valid/ready handshake. It supports pipeline flush.

---
 rtl/cvt_shift_seq_if.sv | 27 ++
 rtl/cvt_shift_seq.sv | 122 ++++++++++++
 tb/tb_cvt_shift_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cvt_shift_seq_if.sv
// Request/response handshake bundle for the iterative conversion shift sequencer.
// The slave modport is the sequencer side, the master modport is the requester/consumer side.
interface cvt_shift_seq_if #(
    parameter int WIDTH = 128,
    parameter int AMTW  = 8
);
    logic             ReqValid;
    logic             ReqReady;
    logic [WIDTH-1:0] ShiftIn;
    logic [AMTW-1:0]  ShiftAmt;
    logic             ShiftRight;
    logic             RespValid;
    logic             RespReady;
    logic [WIDTH-1:0] ShiftOut;
    logic             Sticky;
    logic             Ovf;

    modport slave (
        input  ReqValid, ShiftIn, ShiftAmt, ShiftRight, RespReady,
        output ReqReady, RespValid, ShiftOut, Sticky, Ovf
    );

    modport master (
        output ReqValid, ShiftIn, ShiftAmt, ShiftRight, RespReady,
        input  ReqReady, RespValid, ShiftOut, Sticky, Ovf
    );
endinterface

// File: rtl/cvt_shift_seq.sv
// Multi-cycle shifter for the conversion post-processing path: shifts by at most STEP bits per
// cycle, collecting shifted-out ones into Sticky (right) or Ovf (left).
module cvt_shift_seq #(
    parameter int WIDTH = 128,
    parameter int STEP  = 8,
    parameter int AMTW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    output logic              Busy,
    cvt_shift_seq_if.slave    bus
);
    localparam int REMW  = $clog2(WIDTH + 1);
    localparam int STEPW = $clog2(STEP + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;
    logic [REMW-1:0]  r_rem, w_rem_next;
    logic             r_dir, w_dir_next;
    logic             r_sticky, w_sticky_next;
    logic             r_ovf, w_ovf_next;

    logic [STEPW-1:0] w_step;
    logic [REMW-1:0]  w_rem_after;
    logic [REMW-1:0]  w_amt_clamp;
    logic [WIDTH-1:0] w_lo_mask;
    logic [WIDTH-1:0] w_hi_mask;
    logic             w_lost_lo;
    logic             w_lost_hi;

    assign w_step      = (32'(r_rem) < STEP) ? STEPW'(r_rem) : STEPW'(STEP);
    assign w_rem_after = r_rem - REMW'(w_step);
    // Amounts at or beyond the vector width shift everything out; clamping keeps Rem from wrapping.
    assign w_amt_clamp = (32'(bus.ShiftAmt) >= WIDTH) ? REMW'(WIDTH) : REMW'(bus.ShiftAmt);

    // Masks select the bits that leave the vector this cycle for either direction.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign w_lo_mask[gi] = (gi < 32'(w_step));
            assign w_hi_mask[gi] = (gi >= WIDTH - 32'(w_step));
        end
    endgenerate

    assign w_lost_lo = |(r_acc & w_lo_mask);
    assign w_lost_hi = |(r_acc & w_hi_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            r_sticky <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_rem    <= w_rem_next;
            r_dir    <= w_dir_next;
            r_sticky <= w_sticky_next;
            r_ovf    <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_acc_next    = r_acc;
        w_rem_next    = r_rem;
        w_dir_next    = r_dir;
        w_sticky_next = r_sticky;
        w_ovf_next    = r_ovf;
        bus.ReqReady  = 1'b0;
        bus.RespValid = 1'b0;
        bus.ShiftOut  = r_acc;
        bus.Sticky    = r_sticky;
        bus.Ovf       = r_ovf;
        Busy          = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                bus.ReqReady = 1'b1;
                if (bus.ReqValid && !Flush) begin
                    w_acc_next    = bus.ShiftIn;
                    w_rem_next    = w_amt_clamp;
                    w_dir_next    = bus.ShiftRight;
                    w_sticky_next = 1'b0;
                    w_ovf_next    = 1'b0;
                    w_state_next  = (w_amt_clamp == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (Flush) begin
                    w_state_next = IDLE;
                end else begin
                    w_rem_next = w_rem_after;
                    if (r_dir) begin
                        w_acc_next    = r_acc >> w_step;
                        w_sticky_next = r_sticky | w_lost_lo;
                    end else begin
                        w_acc_next = r_acc << w_step;
                        w_ovf_next = r_ovf | w_lost_hi;
                    end
                    if (w_rem_after == '0) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                bus.RespValid = 1'b1;
                if (Flush || bus.RespReady) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cvt_shift_seq.sv
// Directed bench for cvt_shift_seq: shifts, clamping, backpressure, flush and async reset,
// each checked against hand-computed results and edge counts.
module tb_cvt_shift_seq;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic Flush = 1'b0;
    logic Busy;

    int n_total = 0;
    int n_bad   = 0;

    cvt_shift_seq_if #(.WIDTH(128), .AMTW(8)) bus();

    cvt_shift_seq #(.WIDTH(128), .STEP(8), .AMTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .Flush (Flush),
        .Busy  (Busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let it be accepted, then scramble the inputs and wait for RespValid.
    // edges counts clock edges from the accept edge (inclusive) to RespValid becoming visible.
    task automatic send_and_wait(input logic [7:0] amt, input logic [127:0] din,
                                 input logic right, output int edges);
        @(negedge clk);
        check("req_ready_idle", 128'(bus.ReqReady), 128'd1);
        bus.ReqValid   = 1'b1;
        bus.ShiftIn    = din;
        bus.ShiftAmt   = amt;
        bus.ShiftRight = right;
        @(posedge clk);
        edges = 1;
        #1;
        bus.ReqValid   = 1'b0;
        bus.ShiftIn    = ~din;
        bus.ShiftAmt   = 8'd5;
        bus.ShiftRight = ~right;
        while (!bus.RespValid && edges < 300) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    task automatic txn(input string tag, input logic [7:0] amt, input logic [127:0] din,
                       input logic right, input logic [127:0] exp_out, input logic exp_st,
                       input logic exp_ov, input int exp_lat);
        int edges;
        send_and_wait(amt, din, right, edges);
        check({tag, "_lat"}, 128'(edges), 128'(exp_lat));
        check({tag, "_out"}, bus.ShiftOut, exp_out);
        check({tag, "_sticky"}, 128'(bus.Sticky), 128'(exp_st));
        check({tag, "_ovf"}, 128'(bus.Ovf), 128'(exp_ov));
        $display("txn %s amt=%0d right=%0d out=%h sticky=%0d ovf=%0d lat=%0d",
                 tag, amt, right, bus.ShiftOut, bus.Sticky, bus.Ovf, edges);
        @(posedge clk);
        #1;
        check({tag, "_resp_drop"}, 128'(bus.RespValid), 128'd0);
        check({tag, "_ready_back"}, 128'(bus.ReqReady), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  edges;
        logic seen;

        bus.ReqValid   = 1'b0;
        bus.ShiftIn    = '0;
        bus.ShiftAmt   = '0;
        bus.ShiftRight = 1'b0;
        bus.RespReady  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 128'(bus.ReqReady), 128'd1);
        check("rst_resp_valid", 128'(bus.RespValid), 128'd0);
        check("rst_busy", 128'(Busy), 128'd0);
        check("rst_out", bus.ShiftOut, 128'd0);
        check("rst_flags", {126'd0, bus.Sticky, bus.Ovf}, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        txn("left20",   8'd20,  128'd1,        1'b0, 128'h100000, 1'b0, 1'b0, 4);
        txn("rightFF",  8'd4,   128'hFF,       1'b1, 128'h0F,     1'b1, 1'b0, 2);
        txn("rightF0",  8'd4,   128'hF0,       1'b1, 128'h0F,     1'b0, 1'b0, 2);
        txn("zero",     8'd0,   128'hABCD,     1'b0, 128'hABCD,   1'b0, 1'b0, 1);
        txn("clampR",   8'd200, 128'd1,        1'b1, 128'd0,      1'b1, 1'b0, 17);
        txn("msbL1",    8'd1,   128'd1 << 127, 1'b0, 128'd0,      1'b0, 1'b1, 2);
        txn("right9",   8'd9,   128'h3FF,      1'b1, 128'h1,      1'b1, 1'b0, 3);
        txn("left127",  8'd127, 128'h3,        1'b0, 128'd1 << 127, 1'b0, 1'b1, 17);
        txn("right127", 8'd127, 128'd1 << 127, 1'b1, 128'h1,      1'b0, 1'b0, 17);
        txn("left128",  8'd128, 128'h1,        1'b0, 128'd0,      1'b0, 1'b1, 17);

        // Backpressure: result must hold while the consumer stalls.
        bus.RespReady = 1'b0;
        send_and_wait(8'd12, 128'h12345678, 1'b1, edges);
        check("bp_lat", 128'(edges), 128'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ReqValid = 1'b1;
            bus.ShiftIn  = 128'hDEAD;
            bus.ShiftAmt = 8'd1;
            @(posedge clk);
            #1;
            check("bp_out", bus.ShiftOut, 128'h12345);
            check("bp_flags", {126'd0, bus.Sticky, bus.Ovf}, 128'b10);
            check("bp_valid", 128'(bus.RespValid), 128'd1);
            check("bp_req_ready", 128'(bus.ReqReady), 128'd0);
        end
        @(negedge clk);
        bus.ReqValid  = 1'b0;
        bus.RespReady = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 128'(bus.RespValid), 128'd0);
        check("bp_release_ready", 128'(bus.ReqReady), 128'd1);
        @(posedge clk);
        #1;
        check("bp_no_stale_accept", 128'(Busy), 128'd0);
        $display("txn backpressure out=%h sticky=%0d", 128'h12345, 1);

        // Flush in the second SHIFT cycle of a 40-bit shift.
        @(negedge clk);
        bus.ReqValid   = 1'b1;
        bus.ShiftIn    = 128'd1;
        bus.ShiftAmt   = 8'd40;
        bus.ShiftRight = 1'b0;
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        @(posedge clk);
        #1;
        check("fl_busy_before", 128'(Busy), 128'd1);
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        check("fl_busy", 128'(Busy), 128'd0);
        check("fl_ready", 128'(bus.ReqReady), 128'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | bus.RespValid;
        end
        check("fl_no_resp", 128'(seen), 128'd0);
        $display("txn flush_shift amt=40");

        // Flush together with a request in IDLE blocks the accept.
        @(negedge clk);
        bus.ReqValid = 1'b1;
        Flush        = 1'b1;
        bus.ShiftAmt = 8'd3;
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        Flush        = 1'b0;
        check("fl_idle_busy", 128'(Busy), 128'd0);
        @(posedge clk);
        #1;
        check("fl_idle_still", 128'(Busy) | 128'(bus.RespValid), 128'd0);
        $display("txn flush_idle");

        // Flush while a result waits in DONE discards it.
        bus.RespReady = 1'b0;
        send_and_wait(8'd0, 128'h5, 1'b0, edges);
        check("fl_done_valid", 128'(bus.RespValid), 128'd1);
        @(negedge clk);
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush         = 1'b0;
        bus.RespReady = 1'b1;
        check("fl_done_drop", 128'(bus.RespValid), 128'd0);
        $display("txn flush_done");

        // Asynchronous reset between edges while shifting.
        @(negedge clk);
        bus.ReqValid   = 1'b1;
        bus.ShiftIn    = 128'd1;
        bus.ShiftAmt   = 8'd100;
        bus.ShiftRight = 1'b0;
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("ar_busy", 128'(Busy), 128'd0);
        check("ar_valid", 128'(bus.RespValid), 128'd0);
        check("ar_ready", 128'(bus.ReqReady), 128'd1);
        check("ar_out", bus.ShiftOut, 128'd0);
        check("ar_flags", {126'd0, bus.Sticky, bus.Ovf}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("txn async_reset");

        txn("post_rst", 8'd8, 128'hFF, 1'b0, 128'hFF00, 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
